huffman_bit_packer: RTL and testbench

Downstream stage of `huffman_coder`. Consumes variable-length Huffman codes (`huffman_out`, `bit_length`, `valid_out`) and packs them MSB-first into a contiguous bitstream. Emits one byte at a time over a valid/ready handshake. An explicit flush pads and emits the trailing partial byte with zeros.

---
 rtl/huffman_pkg.sv | 16 +
 rtl/byte_out_slot.sv | 50 +++++
 rtl/huffman_bit_packer.sv | 97 +++++++++
 tb/tb_huffman_bit_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared constants and state encoding for the Huffman bitstream packer.
package huffman_pkg;

    localparam int unsigned CODE_W = 10;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } packer_state_t;

endpackage

// File: rtl/byte_out_slot.sv
// Single-entry output byte register with valid/ready hold and a wrapping hand-off counter.
module byte_out_slot
    import huffman_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              byte_ready_i,
    output logic              slot_free_o,
    output logic [BYTE_W-1:0] byte_out_o,
    output logic              byte_valid_o,
    output logic [15:0]       byte_count_o
);

    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [15:0]       count_q, count_d;

    assign slot_free_o = !valid_q || byte_ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (byte_ready_i) begin
            valid_d = 1'b0;
        end
        count_d = count_q + 16'(valid_q && byte_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign byte_out_o   = data_q;
    assign byte_valid_o = valid_q;
    assign byte_count_o = count_q;

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into bytes, with zero-padded flush.
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int unsigned CODE_W = 10,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] huffman_in,
    input  logic [LEN_W-1:0]  bit_length,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              flush,
    output logic              flush_done,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [15:0]       byte_count
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    packer_state_t     state_q;
    logic              flush_done_q;

    logic              flush_pend, slot_free, accept, emit, drain, load;
    logic [LEN_W-1:0]  len;
    logic [CODE_W-1:0] code_m;
    logic [ACC_W-1:0]  aligned;

    assign flush_pend = (state_q == FLUSH);
    assign ready_out  = (bit_cnt_q < CNT_W'(8)) && !flush_pend;
    assign accept     = valid_in && ready_out;
    assign emit       = (bit_cnt_q >= CNT_W'(8)) && slot_free;
    assign drain      = flush_pend && (bit_cnt_q < CNT_W'(8)) && slot_free;

    assign len     = (bit_length > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : bit_length;
    assign code_m  = huffman_in & CODE_W'((32'd1 << len) - 32'd1);
    // Left-justify the code to bit 17, then drop it in just below the pending bits.
    assign aligned = (ACC_W'(code_m) << (ACC_W - 32'(len))) >> bit_cnt_q;

    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        if (accept) begin
            acc_d     = acc_q | aligned;
            bit_cnt_d = bit_cnt_q + CNT_W'(len);
        end else if (emit) begin
            load      = 1'b1;
            acc_d     = acc_q << BYTE_W;
            bit_cnt_d = bit_cnt_q - CNT_W'(BYTE_W);
        end else if (drain) begin
            load      = (bit_cnt_q != '0);
            acc_d     = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            flush_done_q <= drain;
            if (flush_pend) begin
                if (drain) begin
                    state_q <= IDLE;
                end
            end else if (flush) begin
                state_q <= FLUSH;
            end else begin
                state_q <= (bit_cnt_d >= CNT_W'(8)) ? DRAIN : IDLE;
            end
        end
    end

    assign flush_done = flush_done_q;

    byte_out_slot u_slot (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (load),
        .data_i       (acc_q[ACC_W-1 -: BYTE_W]),
        .byte_ready_i (byte_ready),
        .slot_free_o  (slot_free),
        .byte_out_o   (byte_out),
        .byte_valid_o (byte_valid),
        .byte_count_o (byte_count)
    );

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer with hand-computed expected bytes and counts.
module tb_huffman_bit_packer;

    logic        clk;
    logic        rst_n;
    logic [9:0]  huffman_in;
    logic [3:0]  bit_length;
    logic        valid_in;
    logic        ready_out;
    logic        flush;
    logic        flush_done;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] byte_count;

    int total = 0;
    int bad   = 0;

    huffman_bit_packer #(
        .CODE_W (10),
        .LEN_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .huffman_in (huffman_in),
        .bit_length (bit_length),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .flush      (flush),
        .flush_done (flush_done),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] code, input logic [3:0] len);
        int n = 0;
        huffman_in = code;
        bit_length = len;
        valid_in   = 1'b1;
        while (!ready_out && n < 20) begin
            cyc();
            n++;
        end
        if (!ready_out) begin
            total++;
            bad++;
            $error("FAIL send_ready observed=0 expected=1");
        end
        cyc();
        valid_in = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        huffman_in = '0;
        bit_length = '0;
        valid_in   = 1'b0;
        flush      = 1'b0;
        byte_ready = 1'b1;
        #12;
        chk("rst_byte_out",   32'(byte_out),   32'h00);
        chk("rst_byte_valid", 32'(byte_valid), 32'h0);
        chk("rst_ready_out",  32'(ready_out),  32'h1);
        chk("rst_flush_done", 32'(flush_done), 32'h0);
        chk("rst_byte_count", 32'(byte_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // 101 + 11 + 000 -> 0xB8
        send(10'h5, 4'd3);
        send(10'h3, 4'd2);
        send(10'h0, 4'd3);
        chk("t1_bitcnt8",  32'(dut.bit_cnt_q), 32'd8);
        chk("t1_ready_lo", 32'(ready_out),     32'h0);
        cyc();
        chk("t1_valid",    32'(byte_valid),    32'h1);
        chk("t1_byte",     32'(byte_out),      32'hB8);
        chk("t1_bitcnt0",  32'(dut.bit_cnt_q), 32'd0);
        cyc();
        chk("t1_count",    32'(byte_count),    32'd1);
        chk("t1_valid_lo", 32'(byte_valid),    32'h0);

        // 1010101 + 1111111111 -> 0xAB, 0xFF, one bit left
        send(10'h055, 4'd7);
        send(10'h3FF, 4'd10);
        chk("t2_bitcnt17", 32'(dut.bit_cnt_q), 32'd17);
        chk("t2_ready_lo0", 32'(ready_out),    32'h0);
        cyc();
        chk("t2_byte_ab",  32'(byte_out),      32'hAB);
        chk("t2_ready_lo1", 32'(ready_out),    32'h0);
        cyc();
        chk("t2_byte_ff",  32'(byte_out),      32'hFF);
        chk("t2_valid",    32'(byte_valid),    32'h1);
        chk("t2_bitcnt1",  32'(dut.bit_cnt_q), 32'd1);
        chk("t2_ready_hi", 32'(ready_out),     32'h1);
        pulse_flush();
        chk("t2_pend_ready", 32'(ready_out),   32'h0);
        chk("t2_fd_early", 32'(flush_done),    32'h0);
        cyc();
        chk("t2_fd",       32'(flush_done),    32'h1);
        chk("t2_byte_80",  32'(byte_out),      32'h80);
        chk("t2_valid80",  32'(byte_valid),    32'h1);
        cyc();
        chk("t2_fd_lo",    32'(flush_done),    32'h0);
        chk("t2_count",    32'(byte_count),    32'd4);

        // Backpressure: 0xB8 held while ten more bits arrive
        byte_ready = 1'b0;
        send(10'h0B8, 4'd8);
        cyc();
        chk("t3_byte_b8",  32'(byte_out),      32'hB8);
        send(10'h2AB, 4'd10);
        chk("t3_ready_lo", 32'(ready_out),     32'h0);
        chk("t3_bitcnt10", 32'(dut.bit_cnt_q), 32'd10);
        cyc();
        chk("t3_hold",     32'(byte_out),      32'hB8);
        chk("t3_count_h",  32'(byte_count),    32'd4);
        byte_ready = 1'b1;
        cyc();
        chk("t3_byte_aa",  32'(byte_out),      32'hAA);
        chk("t3_count5",   32'(byte_count),    32'd5);
        chk("t3_bitcnt2",  32'(dut.bit_cnt_q), 32'd2);
        pulse_flush();
        cyc();
        chk("t3_byte_c0",  32'(byte_out),      32'hC0);
        chk("t3_fd",       32'(flush_done),    32'h1);
        cyc();
        chk("t3_count7",   32'(byte_count),    32'd7);

        // Length edge cases
        send(10'h3FF, 4'd0);
        chk("t4_len0_cnt", 32'(dut.bit_cnt_q), 32'd0);
        chk("t4_len0_acc", 32'(dut.acc_q),     32'h0);
        send(10'h3FF, 4'd15);
        chk("t4_len15",    32'(dut.bit_cnt_q), 32'd10);
        cyc();
        chk("t4_byte_ff",  32'(byte_out),      32'hFF);
        pulse_flush();
        cyc();
        chk("t4_byte_c0",  32'(byte_out),      32'hC0);
        cyc();
        chk("t4_count9",   32'(byte_count),    32'd9);
        pulse_flush();
        chk("t4_fd0_early", 32'(flush_done),   32'h0);
        cyc();
        chk("t4_fd0",      32'(flush_done),    32'h1);
        chk("t4_no_byte",  32'(byte_valid),    32'h0);
        cyc();
        chk("t4_fd0_lo",   32'(flush_done),    32'h0);
        chk("t4_count_eq", 32'(byte_count),    32'd9);
        chk("t4_ready",    32'(ready_out),     32'h1);

        // Asynchronous reset with a held byte and five pending bits
        byte_ready = 1'b0;
        send(10'h0B8, 4'd8);
        cyc();
        send(10'h015, 4'd5);
        chk("t5_pending",  32'(dut.bit_cnt_q), 32'd5);
        chk("t5_held",     32'(byte_valid),    32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid",    32'(byte_valid),    32'h0);
        chk("t5_byte",     32'(byte_out),      32'h00);
        chk("t5_ready",    32'(ready_out),     32'h1);
        chk("t5_count",    32'(byte_count),    32'd0);
        chk("t5_bitcnt",   32'(dut.bit_cnt_q), 32'd0);
        byte_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        send(10'h03C, 4'd6);
        send(10'h002, 4'd2);
        cyc();
        chk("t5_byte_f2",  32'(byte_out),      32'hF2);
        cyc();
        chk("t5_count1",   32'(byte_count),    32'd1);

        // Counter wrap
        force dut.u_slot.count_q = 16'hFFFF;
        cyc();
        release dut.u_slot.count_q;
        #1;
        chk("t6_preload",  32'(byte_count),    32'hFFFF);
        send(10'h00F, 4'd8);
        cyc();
        chk("t6_byte_0f",  32'(byte_out),      32'h0F);
        cyc();
        chk("t6_wrap",     32'(byte_count),    32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
